// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-RAM arbiter: FSM states, read-owner codes and
// the helper that decides which requester owns the read data returning next cycle.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    DRAIN  = 2'd1,
    EXCL   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } rd_owner_e;

  function automatic rd_owner_e read_owner(input logic cpu_gnt, input logic cpu_we,
                                           input logic dbg_gnt, input logic dbg_we);
    if (cpu_gnt && !cpu_we) return OWN_CPU;
    if (dbg_gnt && !dbg_we) return OWN_DBG;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way winner select, purely combinational: one-hot grant from requests,
// an exclusive-owner override and a "dbg wins conflicts" priority bit.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic en_i,
  input  logic excl_i,
  input  logic cpu_req_i,
  input  logic dbg_req_i,
  input  logic dbg_first_i,
  output logic cpu_gnt_o,
  output logic dbg_gnt_o
);

  always_comb begin
    cpu_gnt_o = 1'b0;
    dbg_gnt_o = 1'b0;
    if (en_i) begin
      if (excl_i) begin
        dbg_gnt_o = dbg_req_i;
      end else if (cpu_req_i && dbg_req_i) begin
        cpu_gnt_o = !dbg_first_i;
        dbg_gnt_o = dbg_first_i;
      end else begin
        cpu_gnt_o = cpu_req_i;
        dbg_gnt_o = dbg_req_i;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM shared by the CPU MEM stage and a debug/loader port; grant same cycle, read data one cycle later.
// Define DMEM_ARB_RR_EN for round-robin conflict resolution; otherwise fixed cpu priority with MAX_WAIT starvation override.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_hold,
  output logic              dbg_excl,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  arb_state_e state_q;
  logic       dbg_excl_q;
  rd_owner_e  rd_owner_q;
  rd_owner_e  rd_owner_d;
  logic       grant_en;
  logic       excl_mode;
  logic       dbg_first;

  // Reset also gates grants so no RAM write can leak out during a reset cycle.
  assign grant_en  = rst && (state_q != DRAIN);
  assign excl_mode = (state_q == EXCL);

  dmem_arb_pick u_pick (
    .en_i        (grant_en),
    .excl_i      (excl_mode),
    .cpu_req_i   (cpu_req),
    .dbg_req_i   (dbg_req),
    .dbg_first_i (dbg_first),
    .cpu_gnt_o   (cpu_gnt),
    .dbg_gnt_o   (dbg_gnt)
  );

`ifdef DMEM_ARB_RR_EN
  logic last_cpu_q;
  logic last_cpu_d;
  logic conflict;

  // Only real NORMAL-mode conflicts move the pointer; reset value makes cpu win first.
  assign conflict   = (state_q == NORMAL) && cpu_req && dbg_req;
  assign dbg_first  = last_cpu_q;
  assign last_cpu_d = conflict ? cpu_gnt : last_cpu_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_cpu_q <= 1'b0;
    end else begin
      last_cpu_q <= last_cpu_d;
    end
  end
`else
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_SAT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  assign dbg_first = (wait_cnt_q == WAIT_SAT);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!dbg_req || dbg_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_SAT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= NORMAL;
      dbg_excl_q <= 1'b0;
    end else begin
      case (state_q)
        NORMAL: begin
          if (dbg_hold) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          state_q    <= EXCL;
          dbg_excl_q <= 1'b1;
        end
        EXCL: begin
          if (!dbg_hold) begin
            state_q    <= NORMAL;
            dbg_excl_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= NORMAL;
          dbg_excl_q <= 1'b0;
        end
      endcase
    end
  end

  assign rd_owner_d = read_owner(cpu_gnt, cpu_we, dbg_gnt, dbg_we);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_owner_q <= OWN_NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  assign ram_we   = (cpu_gnt && cpu_we) || (dbg_gnt && dbg_we);
  assign ram_addr = dbg_gnt ? dbg_addr : cpu_addr;
  assign ram_din  = dbg_gnt ? dbg_wdata : cpu_wdata;

  assign cpu_stall  = cpu_req && !cpu_gnt;
  assign dbg_excl   = dbg_excl_q;
  // A read in flight across a reset is dropped, not delivered.
  assign cpu_rvalid = rst && (rd_owner_q == OWN_CPU);
  assign dbg_rvalid = rst && (rd_owner_q == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? ram_dout : '0;
  assign dbg_rdata  = dbg_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a read-data scoreboard and a behavioural RAM.
module tb_dmem_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int MW = 8;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic          clk;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_hold, dbg_excl;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din, ram_dout;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_hold(dbg_hold), .dbg_excl(dbg_excl),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 14'h10) return 32'hDEADBEEF;
    return 32'hC0DE_0000 | DW'(a);
  endfunction

  // Behavioural RAM: registered read, unwritten words return init_val.
  logic [DW-1:0] ram     [0:(1<<AW)-1];
  bit            written [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we === 1'b1) begin
      ram[ram_addr]     <= ram_din;
      written[ram_addr] <= 1'b1;
    end
    ram_dout <= written[ram_addr] ? ram[ram_addr] : init_val(ram_addr);
  end

  typedef struct {
    logic rst_n, creq, cwe;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic dreq, dwe;
    logic [AW-1:0] da;
    logic [DW-1:0] dd;
    logic hold, e_cg, e_dg, e_cs, e_ex;
  } vec_t;

  typedef struct {
    logic          is_cpu;
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  vec_t          tbl[$];
  rd_t           sb[$];
  logic [DW-1:0] ref_mem [int];
  int            den = 0;
  bit            last_cpu = 1'b0;
  int            n_vec = 0;
  int            n_bad = 0;
  int            cyc = 0;

  function automatic void add(input logic rn, input logic creq, input logic cwe,
                              input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                              input logic dreq, input logic dwe,
                              input logic [AW-1:0] da, input logic [DW-1:0] dd,
                              input logic hold, input logic ecg, input logic edg,
                              input logic ecs, input logic eex);
    vec_t v;
    v.rst_n = rn; v.creq = creq; v.cwe = cwe; v.ca = ca; v.cd = cd;
    v.dreq = dreq; v.dwe = dwe; v.da = da; v.dd = dd; v.hold = hold;
    v.e_cg = ecg; v.e_dg = edg; v.e_cs = ecs; v.e_ex = eex;
    tbl.push_back(v);
    if (!rn) begin
      den = 0;
      last_cpu = 1'b0;
    end else if (!dreq || edg) begin
      den = 0;
    end else if (den < MW) begin
      den++;
    end
  endfunction

  // Both sides read in NORMAL mode; the winner follows the arbitration policy.
  function automatic void conflict(input logic [AW-1:0] ca, input logic [AW-1:0] da);
    logic dw;
`ifdef DMEM_ARB_RR_EN
    dw = last_cpu;
    last_cpu = !dw;
`else
    dw = (den == MW);
`endif
    add(H, H, L, ca, '0, H, L, da, '0, L, !dw, dw, dw, L);
  endfunction

  function automatic logic [DW-1:0] rdref(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rd_t it;
    rst = v.rst_n; cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.ca; cpu_wdata = v.cd;
    dbg_req = v.dreq; dbg_we = v.dwe; dbg_addr = v.da; dbg_wdata = v.dd; dbg_hold = v.hold;
    #3;
    if (!v.rst_n) sb.delete();
    if (sb.size() > 0 && sb[0].due == cyc) begin
      it = sb.pop_front();
      chk1("cpu_rvalid", cpu_rvalid, it.is_cpu);
      chk1("dbg_rvalid", dbg_rvalid, !it.is_cpu);
      chkw(it.is_cpu ? "cpu_rdata" : "dbg_rdata", it.is_cpu ? cpu_rdata : dbg_rdata, it.data);
      chkw("loser_rdata", it.is_cpu ? dbg_rdata : cpu_rdata, '0);
    end else begin
      chk1("cpu_rvalid_idle", cpu_rvalid, 1'b0);
      chk1("dbg_rvalid_idle", dbg_rvalid, 1'b0);
    end
    chk1("cpu_gnt", cpu_gnt, v.e_cg);
    chk1("dbg_gnt", dbg_gnt, v.e_dg);
    chk1("cpu_stall", cpu_stall, v.e_cs);
    chk1("dbg_excl", dbg_excl, v.e_ex);
    if (!v.rst_n) chk1("ram_we_in_reset", ram_we, 1'b0);
    if (v.e_cg) begin
      chkw("cpu_ram_addr", DW'(ram_addr), DW'(v.ca));
      chk1("cpu_ram_we", ram_we, v.cwe);
      if (v.cwe) chkw("cpu_ram_din", ram_din, v.cd);
      if (v.cwe) ref_mem[int'(v.ca)] = v.cd;
      else sb.push_back('{1'b1, rdref(v.ca), cyc + 1});
    end
    if (v.e_dg) begin
      chkw("dbg_ram_addr", DW'(ram_addr), DW'(v.da));
      chk1("dbg_ram_we", ram_we, v.dwe);
      if (v.dwe) chkw("dbg_ram_din", ram_din, v.dd);
      if (v.dwe) ref_mem[int'(v.da)] = v.dd;
      else sb.push_back('{1'b0, rdref(v.da), cyc + 1});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_hold = 1'b0;

    // Reset: no grants or RAM writes while rst is low, even with requests present.
    add(L, H, H, 14'h5, 32'h1, H, L, 14'h6, '0, L, L, L, H, L);
    add(L, H, L, 14'h5, '0, L, L, '0, '0, L, L, L, H, L);
    // CPU read of preloaded word, then idle to collect rvalid.
    add(H, H, L, 14'h10, '0, L, L, '0, '0, L, H, L, L, L);
    add(H, L, L, '0, '0, L, L, '0, '0, L, L, L, L, L);
    // Lone dbg read, dbg write then cpu read-back, cpu write then dbg read-back.
    add(H, L, L, '0, '0, H, L, 14'h11, '0, L, L, H, L, L);
    add(H, L, L, '0, '0, H, H, 14'h20, 32'h55, L, L, H, L, L);
    add(H, H, L, 14'h20, '0, L, L, '0, '0, L, H, L, L, L);
    add(H, H, H, 14'h24, 32'hA5A5_1234, L, L, '0, '0, L, H, L, L, L);
    add(H, L, L, '0, '0, H, L, 14'h24, '0, L, L, H, L, L);
    // Hold rises with a granted cpu read: drain delivers it, then exclusive dbg access.
    add(H, H, L, 14'h30, '0, L, L, '0, '0, H, H, L, L, L);
    add(H, H, L, 14'h34, '0, H, H, 14'h40, 32'hCAFE_F00D, H, L, L, H, L);
    add(H, H, L, 14'h34, '0, H, H, 14'h40, 32'hCAFE_F00D, H, L, H, H, H);
    add(H, H, L, 14'h34, '0, H, L, 14'h40, '0, H, L, H, H, H);
    add(H, H, L, 14'h34, '0, L, L, '0, '0, L, L, L, H, H);
    add(H, H, L, 14'h34, '0, L, L, '0, '0, L, H, L, L, L);
    // Hold dropped during drain: one exclusive cycle, then back to normal.
    add(H, L, L, '0, '0, L, L, '0, '0, H, L, L, L, L);
    add(H, H, L, 14'h40, '0, L, L, '0, '0, L, L, L, H, L);
    add(H, H, L, 14'h40, '0, L, L, '0, '0, L, L, L, H, H);
    add(H, H, L, 14'h40, '0, L, L, '0, '0, L, H, L, L, L);
    // Sustained contention.
    for (int k = 0; k < 20; k++) conflict(AW'(14'h100 + k), AW'(14'h200 + k));
    // dbg idle for a cycle restarts its starvation count.
    add(H, H, L, 14'h300, '0, L, L, '0, '0, L, H, L, L, L);
    for (int k = 0; k < 9; k++) conflict(AW'(14'h140 + k), AW'(14'h240 + k));
    // Build up contention history, leave a read in flight, then reset for one cycle.
    for (int k = 0; k < 8; k++) conflict(AW'(14'h180 + k), AW'(14'h280 + k));
    add(L, H, H, 14'h50, 32'h77, H, L, 14'h51, '0, L, L, L, H, L);
    conflict(14'h50, 14'h51);
    add(H, L, L, '0, '0, L, L, '0, '0, L, L, L, L, L);

    @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i]);
    chkw("scoreboard_drained", DW'(sb.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
